// File: rtl/channel_op_arbiter_pkg.sv
// Shared constants for the channel RAM port sequencer: RAM access modes,
// default widths, arbiter state encodings and the op-kind constant.
package channel_op_arbiter_pkg;

    localparam logic RAM_READ  = 1'b0;
    localparam logic RAM_WRITE = 1'b1;

    localparam int ADDRESS_BITS = 8;
    localparam int DATA_BITS    = 16;

    localparam logic OP_SEND = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RUN  = 2'd1,
        ARB_DONE = 2'd2
    } arbState_t;

endpackage

// File: rtl/channel_op_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: returns the first set bit of
// reqVec at or after ptr, wrapping around, plus a valid flag.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] reqVec,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               valid
);

    // Scan offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (reqVec[j[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/channel_op_arbiter.sv
// Round-robin sequencer for the channel RAM port: grants one send/receive
// request at a time, runs the matching engine, and returns its results.
module channel_op_arbiter
    import channel_op_arbiter_pkg::*;
#(
    parameter int addrBits = ADDRESS_BITS,
    parameter int dataBits = DATA_BITS,
    parameter int NUM_REQ  = 4,
    parameter int TIMEOUT  = 31
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ-1:0]           reqIsSend,
    input  logic [NUM_REQ*addrBits-1:0]  reqChannel,
    input  logic [NUM_REQ*addrBits-1:0]  reqPid,
    input  logic [NUM_REQ*dataBits-1:0]  reqMessage,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         ackTimeout,
    output logic                         ackScheduleOther,
    output logic                         ackDeschedule,
    output logic [addrBits-1:0]          ackOtherPid,
    output logic                         ackHasMessage,
    output logic [dataBits-1:0]          ackMessage,
    output logic                         sendEnable,
    output logic                         receiveEnable,
    output logic [addrBits-1:0]          opChannel,
    output logic [addrBits-1:0]          opPid,
    output logic [dataBits-1:0]          opMessage,
    input  logic                         sendFinished,
    input  logic                         sendReadWriteMode,
    input  logic                         receiveFinished,
    input  logic                         receiveReadWriteMode,
    input  logic [addrBits-1:0]          sendAddress,
    input  logic [addrBits-1:0]          receiveAddress,
    input  logic [dataBits-1:0]          sendDataIn,
    input  logic [dataBits-1:0]          receiveDataIn,
    input  logic                         sendScheduleOther,
    input  logic                         sendDeschedule,
    input  logic                         receiveScheduleOther,
    input  logic                         receiveDeschedule,
    input  logic                         receiveHasMessage,
    input  logic [addrBits-1:0]          sendOtherPid,
    input  logic [addrBits-1:0]          receiveOtherPid,
    input  logic [dataBits-1:0]          receiveMessage,
    output logic [addrBits-1:0]          address,
    output logic                         readWriteMode,
    output logic [dataBits-1:0]          dataIn
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arbState_t            state;
    logic [NUM_REQ-1:0]   mask;
    logic [NUM_REQ-1:0]   eligible;
    logic [IDX_W-1:0]     rrPtr;
    logic [IDX_W-1:0]     grantIdx;
    logic [IDX_W-1:0]     pickIdx;
    logic                 pickValid;
    logic                 opIsSend;
    logic                 engFinished;
    logic                 pickIsSend;
    logic [CNT_W-1:0]     cycleCount;

    logic [addrBits-1:0]  chanArr [NUM_REQ];
    logic [addrBits-1:0]  pidArr  [NUM_REQ];
    logic [dataBits-1:0]  msgArr  [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign chanArr[i] = reqChannel[i*addrBits +: addrBits];
        assign pidArr[i]  = reqPid[i*addrBits +: addrBits];
        assign msgArr[i]  = reqMessage[i*dataBits +: dataBits];
    end

    assign eligible    = req & ~mask;
    assign pickIsSend  = (reqIsSend[pickIdx] == OP_SEND);
    assign engFinished = opIsSend ? sendFinished : receiveFinished;

    rr_pick #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) picker (
        .reqVec(eligible),
        .ptr   (rrPtr),
        .idx   (pickIdx),
        .valid (pickValid)
    );

    // cycleCount counts RUN cycles including the current one, so it starts at 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ARB_IDLE;
            rrPtr            <= '0;
            mask             <= '0;
            grantIdx         <= '0;
            opIsSend         <= 1'b0;
            cycleCount       <= '0;
            opChannel        <= '0;
            opPid            <= '0;
            opMessage        <= '0;
            sendEnable       <= 1'b0;
            receiveEnable    <= 1'b0;
            ack              <= '0;
            ackTimeout       <= 1'b0;
            ackScheduleOther <= 1'b0;
            ackDeschedule    <= 1'b0;
            ackOtherPid      <= '0;
            ackHasMessage    <= 1'b0;
            ackMessage       <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    mask <= '0;
                    if (pickValid) begin
                        grantIdx      <= pickIdx;
                        opIsSend      <= pickIsSend;
                        opChannel     <= chanArr[pickIdx];
                        opPid         <= pidArr[pickIdx];
                        opMessage     <= msgArr[pickIdx];
                        cycleCount    <= CNT_W'(1);
                        sendEnable    <= pickIsSend;
                        receiveEnable <= !pickIsSend;
                        state         <= ARB_RUN;
                    end
                end
                ARB_RUN: begin
                    cycleCount <= cycleCount + 1'b1;
                    if (engFinished) begin
                        sendEnable     <= 1'b0;
                        receiveEnable  <= 1'b0;
                        ack[grantIdx]  <= 1'b1;
                        ackTimeout     <= 1'b0;
                        if (opIsSend) begin
                            ackScheduleOther <= sendScheduleOther;
                            ackDeschedule    <= sendDeschedule;
                            ackOtherPid      <= sendOtherPid;
                            ackHasMessage    <= 1'b0;
                        end else begin
                            ackScheduleOther <= receiveScheduleOther;
                            ackDeschedule    <= receiveDeschedule;
                            ackOtherPid      <= receiveOtherPid;
                            ackHasMessage    <= receiveHasMessage;
                            ackMessage       <= receiveMessage;
                        end
                        state <= ARB_DONE;
                    end else if (cycleCount == CNT_W'(TIMEOUT)) begin
                        sendEnable       <= 1'b0;
                        receiveEnable    <= 1'b0;
                        ack[grantIdx]    <= 1'b1;
                        ackTimeout       <= 1'b1;
                        ackScheduleOther <= 1'b0;
                        ackDeschedule    <= 1'b0;
                        ackHasMessage    <= 1'b0;
                        state            <= ARB_DONE;
                    end
                end
                ARB_DONE: begin
                    ack            <= '0;
                    rrPtr          <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
                    mask           <= '0;
                    mask[grantIdx] <= 1'b1;
                    state          <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    // The RAM port follows the running engine with no added latency.
    always_comb begin
        address       = '0;
        dataIn        = '0;
        readWriteMode = RAM_READ;
        if (state == ARB_RUN) begin
            if (opIsSend) begin
                address       = sendAddress;
                dataIn        = sendDataIn;
                readWriteMode = sendReadWriteMode;
            end else begin
                address       = receiveAddress;
                dataIn        = receiveDataIn;
                readWriteMode = receiveReadWriteMode;
            end
        end
    end

endmodule
